// File: rtl/mash_freq_ctrl.sv
// Frequency-word sequencer for the MASH 1-1-1 modulator: jumps or ramps the
// {integer, fractional} input word to a host target, then holds a settle interval.
module mash_freq_ctrl #(
  parameter int INT_W   = 4,
  parameter int FRAC_W  = 16,
  parameter int NSTEP_W = 8,
  parameter int SETTLE  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [INT_W-1:0]   cfg_int,
  input  logic [FRAC_W-1:0]  cfg_frac,
  input  logic               cfg_mode,
  input  logic [FRAC_W-1:0]  cfg_step,
  input  logic [NSTEP_W-1:0] cfg_nsteps,
  input  logic               abort,
  output logic [INT_W-1:0]   core_int,
  output logic [FRAC_W-1:0]  core_frac,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int WORD_W = INT_W + FRAC_W;
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RAMP   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [WORD_W-1:0]  w_q,       w_d;
  logic [WORD_W-1:0]  tgt_q,     tgt_d;
  logic [WORD_W-1:0]  step_q,    step_d;
  logic [NSTEP_W-1:0] cnt_q,     cnt_d;
  logic [SET_W-1:0]   settle_q,  settle_d;
  logic               done_q,    done_d;
  logic               aborted_q, aborted_d;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort is deliberately not looked at here: an idle abort is a no-op
        if (cfg_valid) begin
          tgt_d  = {cfg_int, cfg_frac};
          step_d = {{INT_W{cfg_step[FRAC_W-1]}}, cfg_step};
          if (cfg_mode && (cfg_nsteps != '0)) begin
            cnt_d   = cfg_nsteps;
            state_d = ST_RAMP;
          end else begin
            w_d      = {cfg_int, cfg_frac};
            settle_d = SETTLE_INIT;
            state_d  = ST_SETTLE;
          end
        end
      end

      ST_RAMP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q > NSTEP_W'(1)) begin
          w_d   = w_q + step_q;
          cnt_d = cnt_q - NSTEP_W'(1);
        end else begin
          // Final step lands exactly on the target, hiding step rounding error
          w_d      = tgt_q;
          cnt_d    = '0;
          settle_d = SETTLE_INIT;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (settle_q == SET_W'(1)) begin
          settle_d = '0;
          state_d  = ST_IDLE;
          done_d   = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      tgt_q     <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign core_int  = w_q[WORD_W-1:FRAC_W];
  assign core_frac = w_q[FRAC_W-1:0];
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: doc/mash_freq_ctrl.md
# mash_freq_ctrl

Frequency-word sequencer for the MASH 1-1-1 fractional-N modulator core. Accepts target words (integer + fractional) from the host over a valid/ready handshake. Drives the core's `in_i`/`in_f` either by an immediate jump or by a linear ramp of programmable step and length. Holds a settle interval after each change and signals completion. It is the only writer of the modulator's input word.

## Interface
- `INT_W`, default 4: integer word width; must match the core's `in_i`.
- `FRAC_W`, default 16: fractional word width; must match the core's `in_f`.
- `NSTEP_W`, default 8: width of the ramp step count.
- `SETTLE`, default 3: settle cycles after the final word change; legal range ≥1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_valid`  in  1  host request valid.
- `cfg_ready`  out  1  high only when state is IDLE (combinational from state).
- `cfg_int`  in  INT_W  target integer part.
- `cfg_frac`  in  FRAC_W  target fractional part.
- `cfg_mode`  in  1  0 = jump, 1 = ramp.
- `cfg_step`  in  FRAC_W  signed ramp increment, two's complement, in fractional LSBs.
- `cfg_nsteps`  in  NSTEP_W  ramp length in cycles.
- `abort`  in  1  cancel the active sequence.
- `core_int`  out  INT_W  registered; to the core's `in_i`.
- `core_frac`  out  FRAC_W  registered; to the core's `in_f`.
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse on abort.

## Operation
- Internal word W = {core_int, core_frac}, width INT_W+FRAC_W (20 bits by default). All arithmetic on W is modulo 2^(INT_W+FRAC_W): wrap-around, no saturation.
- T = {cfg_int, cfg_frac}, captured at acceptance. The step is sign-extended to W width and captured at acceptance.
- Reset values:
  - W = 0, state IDLE.
  - `busy` = 0, `done` = 0, `aborted` = 0, `cfg_ready` = 1.
  - Step and count registers = 0.
- Acceptance: `cfg_valid && cfg_ready` sampled at a rising edge. In non-IDLE states `cfg_valid` is ignored and never queued; the host holds its request.
- States:
  - IDLE, on acceptance:
    - Jump (`cfg_mode` = 0), or ramp with `cfg_nsteps` = 0: W ← T, settle counter ← SETTLE, go to SETTLE.
    - Ramp with `cfg_nsteps` = N ≥ 1: W unchanged, count ← N, go to RAMP.
  - RAMP, each cycle:
    - If count > 1: W ← W + step, count ← count − 1.
    - If count = 1: W ← T exactly (the last step forces the target regardless of step accuracy), settle counter ← SETTLE, go to SETTLE.
  - SETTLE: decrement the settle counter each cycle. At the cycle where it reaches 0: go to IDLE and assert `done` for one cycle.
- `abort` in RAMP or SETTLE: next edge → IDLE. W frozen at its current value (no step applied on that edge). `aborted` asserted for one cycle; `done` is not asserted.
- `abort` in IDLE is ignored. `abort` together with `cfg_valid` in IDLE: the request is accepted.
- `abort` in the same cycle as the final RAMP/SETTLE transition: abort wins; no `done`.
- `done` and `aborted` are never high together. Both fall after one cycle.

## Timing
- Acceptance edge is E0.
- Jump:
  - W = T visible after E0.
  - `busy` high for SETTLE cycles (after E0 through E(SETTLE−1)).
  - `done` and `cfg_ready` high in the cycle after E(SETTLE).
- Ramp with N steps:
  - Intermediate W updates at edges E1..E(N−1); W = T after E(N).
  - `done` in the cycle after E(N+SETTLE).
- Back-to-back: a new request may be accepted in the `done` cycle. Throughput is one request per (N + SETTLE + 1) cycles, minimum SETTLE + 1.
- Outputs change only on clk edges, except through async reset.

## Test plan
- Reset mid-ramp (assert `rst_n` low at any cycle) → W = 0x00000, `busy` = 0, `cfg_ready` = 1, no `done`/`aborted` pulses, immediately and asynchronously.
- Jump with `cfg_int` = 5, `cfg_frac` = 0x8000, SETTLE = 3 → W = 0x58000 after E0; `busy` 3 cycles; `done` pulse after E3; `cfg_valid` held during busy is accepted only in the `done` cycle.
- Ramp from 0x58000 to T = 0x60000, step 0x2000, N = 4 → W = 0x5A000, 0x5C000, 0x5E000, 0x60000 at E1..E4; `done` after E7.
- Negative ramp with wrap from W = 0x00000, step 0xF000 (−0x1000), N = 3, T = 0xFD000 → W = 0xFF000, 0xFE000, 0xFD000; `done` after E6.
- Abort asserted for the cycle ending at E2 of the ramp in the first ramp test → W stays 0x5A000; `aborted` pulse; no `done`; `cfg_ready` = 1 after E2. A subsequent abort in IDLE has no effect.
- Ramp with N = 0, T = 0x31234 → behaves as a jump: W = 0x31234 after E0, `done` after E3. A same-cycle `abort` + `cfg_valid` in IDLE → request accepted.
